// File: rtl/bp_pkg.sv
// Shared types and encodings for the branch predictor controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_NOT_TAKEN = 2'b00,
        BP_ONE_BIT   = 2'b01,
        BP_TWO_BIT   = 2'b10
    } bp_mode_e;

    // Bit 1 of every encoding is the predicted direction.
    localparam logic [1:0] WNT = 2'b00;
    localparam logic [1:0] SNT = 2'b01;
    localparam logic [1:0] WT  = 2'b11;
    localparam logic [1:0] ST  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bp_state_e;

endpackage

// File: rtl/pht_next_state.sv
// Next-state function for one PHT counter under the selected policy.
// Latency: purely combinational.
// Backpressure: none; mode 00/11 returns the history unchanged.
module pht_next_state
    import bp_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [1:0] history,
    input  logic       taken,
    output logic [1:0] next_history
);

    always_comb begin
        next_history = history;
        case (mode)
            BP_ONE_BIT: next_history = taken ? WT : WNT;
            BP_TWO_BIT: begin
                case (history)
                    WNT:     next_history = taken ? ST  : SNT;
                    SNT:     next_history = taken ? WNT : SNT;
                    WT:      next_history = taken ? ST  : SNT;
                    default: next_history = taken ? ST  : WT;
                endcase
            end
            default: next_history = history;
        endcase
    end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// PHT owner: fetch lookups, 2-stage execute updates, and a clear sweep.
// Latency: lookup response 1 cycle after accept; update written 1 cycle after accept.
// Backpressure: pred_ready/upd_ready drop only while a clear sweep runs.
module branch_predictor_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_resp_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        upd_ready,
    input  logic        clear_req,
    output logic        clear_busy
);

    logic [1:0]       pht [ENTRIES];
    bp_state_e        state;
    logic [IDX_W-1:0] clr_idx;
    logic             s1_vld;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_taken;
    logic [1:0]       s1_next;
    logic [1:0]       fwd_hist;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             pred_acc;
    logic             upd_acc;
    logic             predict_en;
    logic             unused_pc_bits;

    assign pred_idx   = pred_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign clear_busy = (state == CLEAR);
    assign pred_ready = !clear_busy;
    assign upd_ready  = !clear_busy;
    assign pred_acc   = pred_valid && pred_ready;
    assign upd_acc    = upd_valid && upd_ready;
    assign predict_en = (mode == BP_ONE_BIT) || (mode == BP_TWO_BIT);

    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    pht_next_state u_next_state (
        .mode         (mode),
        .history      (pht[s1_idx]),
        .taken        (s1_taken),
        .next_history (s1_next)
    );

    // A lookup racing the stage-1 write to the same entry sees the post-write value.
    assign fwd_hist = (s1_vld && (s1_idx == pred_idx)) ? s1_next : pht[pred_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= WNT;
            end
            state           <= IDLE;
            clr_idx         <= '0;
            s1_vld          <= 1'b0;
            s1_idx          <= '0;
            s1_taken        <= 1'b0;
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
        end else begin
            pred_resp_valid <= pred_acc;
            if (pred_acc) begin
                pred_taken <= predict_en && fwd_hist[1];
            end

            s1_vld <= upd_acc;
            if (upd_acc) begin
                s1_idx   <= upd_idx;
                s1_taken <= upd_taken;
            end
            if (s1_vld) begin
                pht[s1_idx] <= s1_next;
            end

            // Sweep write comes last so it wins over a same-cycle stage-1 write.
            case (state)
                IDLE: begin
                    if (clear_req && !s1_vld) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    pht[clr_idx] <= WNT;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(ENTRIES - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl with hand-computed expectations.
// Inputs are driven and outputs sampled 1ns after each rising clock edge.
module tb_branch_predictor_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_ready;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;

    int n_vec  = 0;
    int n_miss = 0;

    branch_predictor_ctrl #(.ENTRIES(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .mode            (mode),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_ready      (pred_ready),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_ready       (upd_ready),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        pred_valid = 1'b0;
        check({tag, "_vld"}, 32'(pred_resp_valid), 32'd1);
        check(tag, 32'(pred_taken), 32'(exp));
    endtask

    // Accept one update, then let stage-1 commit it.
    task automatic update(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
        tick();
    endtask

    initial begin
        int busy_cycles;

        tick();
        tick();
        check("rst_pred_ready", 32'(pred_ready), 32'd1);
        check("rst_upd_ready", 32'(upd_ready), 32'd1);
        check("rst_resp_valid", 32'(pred_resp_valid), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        reset = 1'b0;

        mode = 2'b10;
        tick();
        lookup("init_0x40", 32'h40, 1'b0);
        tick();
        check("idle_resp_valid", 32'(pred_resp_valid), 32'd0);

        // Two back-to-back taken updates: 00 -> 10 -> 10.
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        tick();
        tick();
        upd_valid = 1'b0;
        tick();
        lookup("b2b_taken", 32'h40, 1'b1);
        tick();
        check("hold_vld", 32'(pred_resp_valid), 32'd0);
        check("hold_taken", 32'(pred_taken), 32'd1);

        update(32'h40, 1'b0);
        lookup("st_nt_to_wt", 32'h40, 1'b1);
        update(32'h40, 1'b0);
        lookup("wt_nt_to_snt", 32'h40, 1'b0);

        // Update accepted at t, lookup accepted at t+1 must see the write.
        upd_valid = 1'b1;
        upd_pc    = 32'h8;
        upd_taken = 1'b1;
        tick();
        upd_valid  = 1'b0;
        pred_valid = 1'b1;
        pred_pc    = 32'h8;
        tick();
        pred_valid = 1'b0;
        check("fwd_taken", 32'(pred_taken), 32'd1);

        mode = 2'b01;
        tick();
        lookup("m1_trained", 32'h8, 1'b1);
        update(32'h8, 1'b0);
        lookup("m1_nt", 32'h8, 1'b0);

        // Same-cycle lookup and update: lookup sees the pre-update entry.
        upd_valid  = 1'b1;
        upd_pc     = 32'h8;
        upd_taken  = 1'b1;
        pred_valid = 1'b1;
        pred_pc    = 32'h8;
        tick();
        upd_valid  = 1'b0;
        pred_valid = 1'b0;
        check("simul_upd_rdy", 32'(upd_ready), 32'd1);
        check("simul_lookup", 32'(pred_taken), 32'd0);
        tick();
        lookup("m1_taken", 32'h8, 1'b1);

        mode = 2'b00;
        tick();
        lookup("m0_pred", 32'h8, 1'b0);
        update(32'h8, 1'b0);
        mode = 2'b11;
        tick();
        lookup("m3_pred", 32'h8, 1'b0);
        mode = 2'b10;
        tick();
        lookup("m0_no_write", 32'h8, 1'b1);

        update(32'h4, 1'b1);
        lookup("pre_clear_0x4", 32'h4, 1'b1);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_pred_ready", 32'(pred_ready), 32'd0);
        check("clr_upd_ready", 32'(upd_ready), 32'd0);
        busy_cycles = clear_busy ? 1 : 0;
        for (int i = 0; i < 40 && clear_busy; i++) begin
            tick();
            if (clear_busy) busy_cycles++;
        end
        check("clr_busy_len", 32'(busy_cycles), 32'd16);
        check("clr_done_ready", 32'(pred_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            lookup($sformatf("clr_entry%0d", i), 32'(i) << 2, 1'b0);
        end

        // Reset in the middle of a sweep, before entry 12 is reached.
        update(32'h30, 1'b1);
        lookup("pre_rst_0x30", 32'h30, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_clr_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_clear_busy", 32'(clear_busy), 32'd0);
        check("arst_pred_ready", 32'(pred_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(clear_busy), 32'd0);
        lookup("post_rst_0x30", 32'h30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
- Branch prediction controller that owns a pattern history table (PHT) of 2-bit counter entries.
- Arbitrates between the fetch-stage lookup port and the execute-stage resolve/update port.
- Selects the prediction policy at run time: always-not-taken, one-bit, or two-bit hysteresis.
- Sequences a table-clear sweep on request; sits between fetch and execute in the pipeline.

Parameters:
- ENTRIES, 16, number of PHT entries (power of two, minimum 4).
- IDX_W, $clog2(ENTRIES), index width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  2  policy select: 00 always-not-taken, 01 one-bit, 10 two-bit hysteresis, 11 treated as 00.
- pred_valid  input  1  fetch lookup request.
- pred_pc  input  32  PC of the looked-up branch.
- pred_ready  output  1  lookup can be accepted.
- pred_resp_valid  output  1  prediction result valid.
- pred_taken  output  1  predicted direction.
- upd_valid  input  1  resolved-branch update request.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_ready  output  1  update can be accepted.
- clear_req  input  1  level request to clear the PHT.
- clear_busy  output  1  clear sweep in progress.

Behaviour:
- Index: idx = pc[IDX_W+1:2].
- Entry encoding: 00 weak-NT, 01 strong-NT, 11 weak-T, 10 strong-T. Bit 1 is the predicted direction.
- Reset (async): all PHT entries = 00. FSM = IDLE. Update stage-1 empty. Outputs: pred_ready=1, upd_ready=1, pred_resp_valid=0, pred_taken=0, clear_busy=0.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on the first edge where clear_req=1 and update stage-1 is empty. The clear counter loads 0.
  - CLEAR writes 00 to entry clr_idx, then increments clr_idx, one entry per cycle.
  - CLEAR -> IDLE after writing entry ENTRIES-1, so the sweep lasts exactly ENTRIES cycles.
  - clear_req is ignored while in CLEAR.
- clear_busy = (state==CLEAR). pred_ready = upd_ready = !clear_busy.
- Lookup: accepted when pred_valid & pred_ready. On the next cycle pred_resp_valid=1 and pred_taken is:
  - mode 00 or 11: 0.
  - otherwise: bit 1 of the entry, with forwarding. If update stage-1 writes the same index in the acceptance cycle, the post-write value is used.
- Lookup non-accept: pred_resp_valid=0 the next cycle and pred_taken holds its last value.
- Update, 2-stage:
  - Cycle 0: accept on upd_valid & upd_ready; capture idx and taken into stage-1.
  - Cycle 1: read the entry, compute the next state, write it at the edge.
- Next-state rules:
  - mode 01: taken -> 11, not taken -> 00, from any state.
  - mode 10: 00 -> T:10 / N:01; 01 -> T:00 / N:01; 11 -> T:10 / N:01; 10 -> T:10 / N:11.
  - mode 00 or 11: no write.
- Back-to-back updates to the same index are legal. The second reads the value written by the first, with no lost update.
- Simultaneous lookup and update on the same cycle are both accepted. There is no priority conflict because updates read and write only in stage-1.
- Mode change takes effect on the next cycle. Table contents are not rewritten by a mode change.
- Reset asserted mid-clear or mid-update: immediate return to the reset state. A partial sweep or a pending update is discarded.

Decomposition:
- Package bp_pkg holds:
  - mode enum (BP_NOT_TAKEN, BP_ONE_BIT, BP_TWO_BIT);
  - counter-state constants (WNT, SNT, WT, ST);
  - FSM enum (IDLE, CLEAR).
- One combinational sub-module, pht_next_state (inputs: mode, history, taken; output: next history). It is shared by the update path and the forwarding path.

Test Plan (ENTRIES=16):
- Reset, mode=10, lookup pc=0x40 -> next cycle pred_resp_valid=1, pred_taken=0.
- mode=10, two taken updates on pc=0x40 in consecutive cycles -> entry 00->10->10; a lookup of 0x40 two cycles after the last accept returns taken=1.
- mode=10, entry at 10, one not-taken update -> entry 11, lookup predicts 1; a second not-taken update -> entry 01, predicts 0.
- Forwarding: entry 00, taken update to pc=0x8 accepted at cycle t, lookup of 0x8 accepted at t+1 -> response at t+2 has taken=1.
- mode=01 after entries trained to 10 -> lookup predicts 1; one not-taken update -> 00, predicts 0. mode=00 -> always 0, no writes.
- clear_req pulse -> clear_busy high for exactly 16 cycles with pred_ready=upd_ready=0, then all entries read 0. Reset asserted at sweep cycle 5 -> clear_busy drops asynchronously and all entries = 00.
